// File: rtl/dual_port_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// dual_port_ram_arbiter_if
//   Request/response bundle between NUM_REQ requesters and the dual-port RAM
//   arbiter. Each vector carries one bit or one slot per requester. Slot i of
//   a packed field is [i*WIDTH +: WIDTH].
//
//   req_valid  requester -> arbiter  request pending
//   req_we     requester -> arbiter  1 = write, 0 = read
//   req_addr   requester -> arbiter  packed RAM addresses
//   req_wdata  requester -> arbiter  packed write data
//   req_ready  arbiter -> requester  grant; a transfer happens on valid && ready
//   rsp_valid  arbiter -> requester  one-cycle pulse when read data returns
//   rsp_data   arbiter -> requester  packed read data; a slot changes only with
//                                    its rsp_valid bit
//
//   modport master : requester side
//   modport slave  : arbiter side
// ---------------------------------------------------------------------------
interface dual_port_ram_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/dual_port_ram_arbiter.sv
// ---------------------------------------------------------------------------
// dual_port_ram_arbiter
//   Shares one external dual-port RAM between NUM_REQ requesters. Every cycle
//   up to two requests are granted in round-robin order: winner A drives RAM
//   port A and winner B drives port B. When A and B target the same address
//   and at least one of them writes, B is held off so the ports never race on
//   one word. Read data is steered back to the requester that issued the read
//   after RD_LATENCY cycles.
//
//   Ports
//     clk             clock, all logic on posedge
//     sync_rst        synchronous reset, active-high
//     bus             request/response bundle (slave modport)
//     ram_clk_en      RAM clock enable, low while in reset
//     ram_wr_en_a/b   RAM write enables
//     ram_addr_a/b    RAM addresses (0 when the port is idle)
//     ram_wr_data_a/b RAM write data
//     ram_rd_reg_rst  RAM read-register reset, high while in reset
//     ram_rd_data_a/b RAM read data, valid RD_LATENCY-1 edges after accept
//
//   The RAM rd_en / rd_clk_en inputs are tied high where the RAM is
//   instantiated, so every granted read produces data.
// ---------------------------------------------------------------------------
module dual_port_ram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  sync_rst,
  dual_port_ram_arbiter_if.slave bus,
  output logic                  ram_clk_en,
  output logic                  ram_wr_en_a,
  output logic                  ram_wr_en_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_wr_data_a,
  output logic [DATA_WIDTH-1:0] ram_wr_data_b,
  output logic                  ram_rd_reg_rst,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_a,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_b
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  // Circular index: base + off, wrapped into 0..NUM_REQ-1 (off < NUM_REQ).
  function automatic idx_t circ_add(input idx_t base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return idx_t'(s);
  endfunction

  // Next round-robin start after the given winner.
  function automatic idx_t wrap_inc(input idx_t i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // Unpacked views of the request payload
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Control state
  idx_t rr_ptr;
  logic rd_vld_a_p [RD_LATENCY];
  logic rd_vld_b_p [RD_LATENCY];

  // Requester id travelling with each read (payload, not reset)
  idx_t rd_id_a_p [RD_LATENCY];
  idx_t rd_id_b_p [RD_LATENCY];

  // Arbitration results
  logic               has_a, has_b, hazard;
  logic               grant_a, grant_b;
  idx_t               idx_a, idx_b, cand_a, cand_b, last_win;
  logic               we_a, we_b;
  logic [NUM_REQ-1:0] ready_vec;

  always_comb begin
    has_a  = 1'b0;
    idx_a  = rr_ptr;
    cand_a = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_a = circ_add(rr_ptr, k);
      if (!has_a && bus.req_valid[cand_a]) begin
        has_a = 1'b1;
        idx_a = cand_a;
      end
    end

    // B searches onward from A, so it can never pick A again.
    has_b  = 1'b0;
    idx_b  = idx_a;
    cand_b = '0;
    for (int k = 1; k < NUM_REQ; k++) begin
      cand_b = circ_add(idx_a, k);
      if (has_a && !has_b && bus.req_valid[cand_b]) begin
        has_b = 1'b1;
        idx_b = cand_b;
      end
    end

    we_a = bus.req_we[idx_a];
    we_b = bus.req_we[idx_b];

    // Two reads of one word are harmless; any write to a shared word is not.
    hazard = has_a && has_b && (addr_arr[idx_a] == addr_arr[idx_b]) && (we_a || we_b);

    grant_a  = has_a && !sync_rst;
    grant_b  = has_b && !hazard && !sync_rst;
    last_win = grant_b ? idx_b : idx_a;

    ready_vec = '0;
    if (grant_a) ready_vec[idx_a] = 1'b1;
    if (grant_b) ready_vec[idx_b] = 1'b1;
  end

  assign bus.req_ready = ready_vec;

  // RAM drive: idle ports sit at address 0 with writes disabled
  always_comb begin
    ram_clk_en     = !sync_rst;
    ram_rd_reg_rst = sync_rst;

    ram_wr_en_a   = grant_a && we_a;
    ram_addr_a    = grant_a ? addr_arr[idx_a]  : '0;
    ram_wr_data_a = grant_a ? wdata_arr[idx_a] : '0;

    ram_wr_en_b   = grant_b && we_b;
    ram_addr_b    = grant_b ? addr_arr[idx_b]  : '0;
    ram_wr_data_b = grant_b ? wdata_arr[idx_b] : '0;
  end

  // Pipeline outputs, aligned with the RAM read data of each port
  logic ret_vld_a, ret_vld_b;
  idx_t ret_id_a, ret_id_b;

  always_comb begin
    ret_vld_a = rd_vld_a_p[RD_LATENCY-1];
    ret_vld_b = rd_vld_b_p[RD_LATENCY-1];
    ret_id_a  = rd_id_a_p[RD_LATENCY-1];
    ret_id_b  = rd_id_b_p[RD_LATENCY-1];
  end

  // ---- Stage p0 .. p(RD_LATENCY-1): read-return valid pipeline and pointer
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      rr_ptr <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        rd_vld_a_p[k] <= 1'b0;
        rd_vld_b_p[k] <= 1'b0;
      end
    end else begin
      if (grant_a) rr_ptr <= wrap_inc(last_win);
      rd_vld_a_p[0] <= grant_a && !we_a;
      rd_vld_b_p[0] <= grant_b && !we_b;
      for (int k = 1; k < RD_LATENCY; k++) begin
        rd_vld_a_p[k] <= rd_vld_a_p[k-1];
        rd_vld_b_p[k] <= rd_vld_b_p[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    rd_id_a_p[0] <= idx_a;
    rd_id_b_p[0] <= idx_b;
    for (int k = 1; k < RD_LATENCY; k++) begin
      rd_id_a_p[k] <= rd_id_a_p[k-1];
      rd_id_b_p[k] <= rd_id_b_p[k-1];
    end
  end

  // ---- Response stage: steer each port's read data to its requester
  // Both ports carry reads accepted on the same edge, so their ids differ.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ret_vld_a && (ret_id_a == idx_t'(i))) begin
          bus.rsp_valid[i]                          <= 1'b1;
          bus.rsp_data[i*DATA_WIDTH +: DATA_WIDTH]  <= ram_rd_data_a;
        end else if (ret_vld_b && (ret_id_b == idx_t'(i))) begin
          bus.rsp_valid[i]                          <= 1'b1;
          bus.rsp_data[i*DATA_WIDTH +: DATA_WIDTH]  <= ram_rd_data_b;
        end else begin
          bus.rsp_valid[i]                          <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dual_port_ram_arbiter
//   Directed bench for dual_port_ram_arbiter with a behavioural two-cycle
//   (HIGH_PERF) dual-port RAM attached. Inputs change on the falling edge and
//   outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_dual_port_ram_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int AW      = 4;

  logic clk = 1'b0;
  logic sync_rst;

  always #5 clk = ~clk;

  dual_port_ram_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic          ram_clk_en, ram_wr_en_a, ram_wr_en_b, ram_rd_reg_rst;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_wr_data_a, ram_wr_data_b;
  logic [DW-1:0] ram_rd_data_a, ram_rd_data_b;

  dual_port_ram_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2)
  ) dut (
    .clk            (clk),
    .sync_rst       (sync_rst),
    .bus            (bus),
    .ram_clk_en     (ram_clk_en),
    .ram_wr_en_a    (ram_wr_en_a),
    .ram_wr_en_b    (ram_wr_en_b),
    .ram_addr_a     (ram_addr_a),
    .ram_addr_b     (ram_addr_b),
    .ram_wr_data_a  (ram_wr_data_a),
    .ram_wr_data_b  (ram_wr_data_b),
    .ram_rd_reg_rst (ram_rd_reg_rst),
    .ram_rd_data_a  (ram_rd_data_a),
    .ram_rd_data_b  (ram_rd_data_b)
  );

  // Behavioural RAM: address sampled on the accept edge, data registered
  // once more, read-during-write returns the old word.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] a_s1, a_s2, b_s1, b_s2;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (ram_rd_reg_rst) begin
      a_s1 <= '0; a_s2 <= '0; b_s1 <= '0; b_s2 <= '0;
    end else if (ram_clk_en) begin
      a_s1 <= mem[ram_addr_a];
      b_s1 <= mem[ram_addr_b];
      a_s2 <= a_s1;
      b_s2 <= b_s1;
      if (ram_wr_en_a) mem[ram_addr_a] <= ram_wr_data_a;
      if (ram_wr_en_b) mem[ram_addr_b] <= ram_wr_data_b;
    end
  end

  assign ram_rd_data_a = a_s2;
  assign ram_rd_data_b = b_s2;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]           = v;
    bus.req_we[i]              = we;
    bus.req_addr[i*AW +: AW]   = a;
    bus.req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic idle_all();
    bus.req_valid = '0;
    bus.req_we    = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [3:0] exp_rdy [7];
  int         grants  [4];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    idle_all();

    // Reset held with every requester asking to write
    sync_rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, AW'(i), 8'hFF);
    repeat (3) begin
      step(); #1;
      check("rst_ready",    bus.req_ready,  4'b0000);
      check("rst_rsp",      bus.rsp_valid,  4'b0000);
      check("rst_rdata",    bus.rsp_data,   32'h0);
      check("rst_wr_a",     ram_wr_en_a,    1'b0);
      check("rst_wr_b",     ram_wr_en_b,    1'b0);
      check("rst_rdregrst", ram_rd_reg_rst, 1'b1);
      check("rst_clk_en",   ram_clk_en,     1'b0);
    end

    // Write then read back through port A
    step(); sync_rst = 1'b0; idle_all(); set_req(0, 1'b1, 1'b1, 4'd3, 8'hA5); #1;
    check("wr_ready",     bus.req_ready,  4'b0001);
    check("wr_en_a",      ram_wr_en_a,    1'b1);
    check("wr_addr_a",    ram_addr_a,     4'd3);
    check("wr_data_a",    ram_wr_data_a,  8'hA5);
    check("wr_en_b_idle", ram_wr_en_b,    1'b0);
    check("addr_b_idle",  ram_addr_b,     4'd0);
    check("run_clk_en",   ram_clk_en,     1'b1);
    check("run_rdregrst", ram_rd_reg_rst, 1'b0);
    step(); idle_all(); set_req(1, 1'b1, 1'b0, 4'd3, 8'h00); #1;
    check("rd_ready",     bus.req_ready,  4'b0010);
    check("rd_wr_en_a",   ram_wr_en_a,    1'b0);
    step(); idle_all(); #1;
    check("rd_rsp_lat1",  bus.rsp_valid,  4'b0000);
    step(); #1;
    check("rd_rsp_lat2",  bus.rsp_valid,  4'b0000);
    step(); #1;
    check("rd_rsp",       bus.rsp_valid,  4'b0010);
    check("rd_slot1",     bus.rsp_data[15:8], 8'hA5);
    step(); #1;
    check("rd_rsp_pulse", bus.rsp_valid,  4'b0000);

    // Continuous reads from all four, pointer restarted at 0
    step(); sync_rst = 1'b1; idle_all();
    exp_rdy = '{4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) grants[i] = 0;
    for (int c = 0; c < 7; c++) begin
      step(); sync_rst = 1'b0; idle_all();
      if (c < 4) begin
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, (i == 3) ? 4'd0 : 4'd3, 8'h00);
      end
      #1;
      check($sformatf("rr_ready_c%0d", c), bus.req_ready, exp_rdy[c]);
      check($sformatf("rr_rsp_c%0d", c), bus.rsp_valid, (c >= 3) ? exp_rdy[c-3] : 4'b0000);
      for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) grants[i]++;
    end
    for (int i = 0; i < NUM_REQ; i++) check($sformatf("rr_grants%0d", i), grants[i], 2);
    check("rr_rdata", bus.rsp_data, 32'h00A5A5A5);

    // Write on A blocks a same-address read on B
    step(); idle_all(); set_req(0, 1'b1, 1'b1, 4'd5, 8'h3C); set_req(1, 1'b1, 1'b0, 4'd5, 8'h00); #1;
    check("hz_ready",    bus.req_ready, 4'b0001);
    check("hz_wr_en_a",  ram_wr_en_a,   1'b1);
    check("hz_addr_a",   ram_addr_a,    4'd5);
    check("hz_wr_en_b",  ram_wr_en_b,   1'b0);
    step(); idle_all(); set_req(1, 1'b1, 1'b0, 4'd5, 8'h00); #1;
    check("hz_retry",    bus.req_ready, 4'b0010);
    step(); idle_all(); #1;
    check("hz_rsp0",     bus.rsp_valid, 4'b0000);
    step(); #1;
    check("hz_rsp1",     bus.rsp_valid, 4'b0000);
    step(); #1;
    check("hz_rsp",      bus.rsp_valid, 4'b0010);
    check("hz_slot1",    bus.rsp_data[15:8], 8'h3C);

    // Same-address reads on both ports, then read A / write B hazard
    step(); idle_all(); set_req(0, 1'b1, 1'b1, 4'd7, 8'h5A); #1;
    check("dr_wr_ready", bus.req_ready, 4'b0001);
    step(); idle_all(); set_req(2, 1'b1, 1'b0, 4'd7, 8'h00); set_req(3, 1'b1, 1'b0, 4'd7, 8'h00); #1;
    check("dr_ready",    bus.req_ready, 4'b1100);
    check("dr_addr_a",   ram_addr_a,    4'd7);
    check("dr_addr_b",   ram_addr_b,    4'd7);
    check("dr_wr_en_b",  ram_wr_en_b,   1'b0);
    step(); idle_all(); set_req(0, 1'b1, 1'b0, 4'd7, 8'h00); set_req(1, 1'b1, 1'b1, 4'd7, 8'h77); #1;
    check("rw_ready",    bus.req_ready, 4'b0001);
    check("rw_wr_en_b",  ram_wr_en_b,   1'b0);
    step(); idle_all(); set_req(1, 1'b1, 1'b1, 4'd7, 8'h77); #1;
    check("rw_retry",    bus.req_ready, 4'b0010);
    check("rw_wr_en_a",  ram_wr_en_a,   1'b1);
    check("rw_rsp_wr",   bus.rsp_valid, 4'b0000);
    step(); idle_all(); #1;
    check("dr_rsp",      bus.rsp_valid, 4'b1100);
    check("dr_slot2",    bus.rsp_data[23:16], 8'h5A);
    check("dr_slot3",    bus.rsp_data[31:24], 8'h5A);
    step(); #1;
    check("rw_rsp",      bus.rsp_valid, 4'b0001);
    check("rw_slot0",    bus.rsp_data[7:0], 8'h5A);
    step(); #1;
    check("wr_no_rsp",   bus.rsp_valid, 4'b0000);

    // Reset one cycle after two reads are accepted
    step(); idle_all(); set_req(0, 1'b1, 1'b0, 4'd3, 8'h00); set_req(1, 1'b1, 1'b0, 4'd3, 8'h00); #1;
    check("mr_ready",    bus.req_ready, 4'b0011);
    step(); sync_rst = 1'b1; idle_all(); #1;
    check("mr_rst_rdy",  bus.req_ready, 4'b0000);
    check("mr_rdregrst", ram_rd_reg_rst, 1'b1);
    step(); sync_rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, 4'd3, 8'h00);
    #1;
    check("mr_ptr0",     bus.req_ready, 4'b0011);
    check("mr_rsp0",     bus.rsp_valid, 4'b0000);
    step(); idle_all(); #1;
    check("mr_discard",  bus.rsp_valid, 4'b0000);
    step(); #1;
    check("mr_rsp2",     bus.rsp_valid, 4'b0000);
    step(); #1;
    check("mr_new_rsp",  bus.rsp_valid, 4'b0011);
    check("mr_slot0",    bus.rsp_data[7:0], 8'hA5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
